// File: rtl/tetris_pkg.sv
// Shared tetromino definitions: piece codes, legal code count and dealer FSM encodings.
package tetris_pkg;

    localparam logic [2:0] PIECE_I = 3'd0;
    localparam logic [2:0] PIECE_O = 3'd1;
    localparam logic [2:0] PIECE_T = 3'd2;
    localparam logic [2:0] PIECE_S = 3'd3;
    localparam logic [2:0] PIECE_Z = 3'd4;
    localparam logic [2:0] PIECE_J = 3'd5;
    localparam logic [2:0] PIECE_L = 3'd6;

    localparam int NUM_PIECES = 7;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } dealer_state_t;

endpackage

// File: rtl/piece_fifo.sv
// Small circular queue of piece codes with head and head+1 read ports.
// Caller guarantees no push when full and no pop when empty.
module piece_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             head_data,
    output logic [W-1:0]             next_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] head_plus;

    assign head_plus = head + 1'b1;
    assign head_data = mem[head];
    assign next_data = mem[head_plus];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= wdata;
                tail      <= tail + 1'b1;
            end
            if (pop) begin
                head <= head_plus;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/piece_dealer.sv
// Samples the free-running random source, queues legal piece codes and deals them
// over a valid/ready handshake. Optional feature macro: NO_REPEAT_EN (one reroll on repeat).
module piece_dealer
    import tetris_pkg::*;
#(
    parameter int NUM_PIECES = tetris_pkg::NUM_PIECES,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              random,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [2:0]              out_piece,
    output logic                    preview_valid,
    output logic [2:0]              preview_piece,
    output logic [$clog2(DEPTH):0]  fill_level,
    output dealer_state_t           debug_state
);

    // Handshake: a piece transfers on any posedge where out_valid && out_ready;
    // out_valid never depends on out_ready, and out_ready while invalid is ignored.

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          legal;
    logic          space;
    logic          accept;
    logic          push;
    logic          pop;
    dealer_state_t state;
    dealer_state_t state_next;

    assign legal = int'(random) < NUM_PIECES;
    // Space is judged on the pre-pop count, so a pop from a full queue frees nothing yet.
    assign space = count < FULL;

`ifdef NO_REPEAT_EN
    logic [2:0] last_piece;
    logic       reroll_used;
    logic       repeat_hit;

    assign repeat_hit = legal && (random == last_piece) && !reroll_used;
    assign accept     = legal && !repeat_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_piece  <= '0;
            reroll_used <= 1'b0;
        end else if (space) begin
            if (accept) begin
                last_piece  <= random;
                reroll_used <= 1'b0;
            end else if (repeat_hit) begin
                reroll_used <= 1'b1;
            end
        end
    end
`else
    assign accept = legal;
`endif

    assign push = space && accept;
    assign pop  = out_valid && out_ready;

    piece_fifo #(
        .DEPTH (DEPTH),
        .W     (3)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .wdata     (random),
        .head_data (out_piece),
        .next_data (preview_piece),
        .count     (count)
    );

    assign out_valid     = count != '0;
    assign preview_valid = count > ONE;
    assign fill_level    = count;
    assign debug_state   = state;

    assign count_next = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (count_next == FULL) state_next = RUN;
            RUN:     if (count_next != FULL) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

endmodule
